// File: rtl/seg_capture_if.sv
// -----------------------------------------------------------------------------
// seg_capture_if
// Bundles the signals between the 7-segment capture block and its environment:
// the monitored display bus on one side and the captured-frame valid/ready
// interface on the other.
//
//   seg_n      7        segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_n  NDIG     digit selects, active-low
//   out_value  4*NDIG   captured frame, digit k in [4k+3:4k]
//   out_err    NDIG     per-digit "pattern not decodable" flags
//   out_valid  1        frame available
//   out_ready  1        consumer accepts the frame
//   overrun    1        sticky: a completed frame was dropped
//   stall      1        watchdog flag (only with SEG_CAPTURE_WATCHDOG_EN)
//
// Modports: slave = the capture block, master = the bus driver / consumer.
// Optional feature macro: SEG_CAPTURE_WATCHDOG_EN adds the stall signal.
// -----------------------------------------------------------------------------
interface seg_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   dig_sel_n;
    logic [4*NDIG-1:0] out_value;
    logic [NDIG-1:0]   out_err;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
`ifdef SEG_CAPTURE_WATCHDOG_EN
    logic              stall;

    modport slave (
        input  seg_n, dig_sel_n, out_ready,
        output out_value, out_err, out_valid, overrun, stall
    );
    modport master (
        output seg_n, dig_sel_n, out_ready,
        input  out_value, out_err, out_valid, overrun, stall
    );
`else
    modport slave (
        input  seg_n, dig_sel_n, out_ready,
        output out_value, out_err, out_valid, overrun
    );
    modport master (
        output seg_n, dig_sel_n, out_ready,
        input  out_value, out_err, out_valid, overrun
    );
`endif
endinterface

// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
// Receive side of a time-multiplexed, active-low 7-segment display bus.
// Each digit is sampled once its (select, segments) pair has been stable for
// SETTLE cycles, decoded back to a hex nibble, and collected into a frame.
// When every digit has been seen the frame is offered on a valid/ready port.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset
//   bus     seg_capture_if.slave (display bus in, frame valid/ready out)
//
// Parameters: NDIG (digits), SETTLE (dwell cycles, 1..15), TIMEOUT (watchdog).
// Optional feature macro: SEG_CAPTURE_WATCHDOG_EN -- adds the stall output and
// a watchdog that discards a partial frame after TIMEOUT cycles without a
// capture. Without it a partial frame waits indefinitely.
// -----------------------------------------------------------------------------
module seg_capture #(
    parameter int NDIG    = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seg_capture_if.slave  bus
);
    localparam int         IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [3:0] SET4 = 4'(SETTLE);

    // Returns {err, nibble}; unknown patterns (blank included) give nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: seg_decode = 5'h00;
            7'b1111001: seg_decode = 5'h01;
            7'b0100100: seg_decode = 5'h02;
            7'b0110000: seg_decode = 5'h03;
            7'b0011001: seg_decode = 5'h04;
            7'b0010010: seg_decode = 5'h05;
            7'b0000010: seg_decode = 5'h06;
            7'b1111000: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0010000: seg_decode = 5'h09;
            7'b0001000: seg_decode = 5'h0A;
            7'b0000011: seg_decode = 5'h0B;
            7'b1000110: seg_decode = 5'h0C;
            7'b0100001: seg_decode = 5'h0D;
            7'b0000110: seg_decode = 5'h0E;
            7'b0001110: seg_decode = 5'h0F;
            default:    seg_decode = 5'h10;
        endcase
    endfunction

    logic [NDIG-1:0]           sel_q;
    logic [6:0]                seg_q;
    logic [3:0]                cnt_q, cnt_d;
    logic [NDIG-1:0]           seen_q, seen_d;
    logic [NDIG-1:0][3:0]      dig_q, dig_d;
    logic [NDIG-1:0]           derr_q, derr_d;
    logic [NDIG-1:0][3:0]      val_q;
    logic [NDIG-1:0]           oerr_q;
    logic                      vld_q, ovr_q;

    logic [NDIG-1:0]           low;
    logic                      one_low, same, capture, frame_done;
    logic [IW-1:0]             idx;
    logic [4:0]                dec;

    // Sample qualification: exactly one select low.
    always_comb begin
        low     = ~bus.dig_sel_n;
        one_low = (low != '0) && ((low & (low - NDIG'(1))) == '0);
        idx     = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (low[k]) idx = IW'(k);
        end
        same = (bus.dig_sel_n == sel_q) && (bus.seg_n == seg_q);
        dec  = seg_decode(bus.seg_n);
    end

    // Dwell counter. Capture fires only on the transition into SETTLE, so a
    // dwell already holding at SETTLE never captures again. The hold test
    // (same pair, count already SETTLE) also covers SETTLE=1, where a fresh
    // pair restarts at 1 == SETTLE and must still capture.
    always_comb begin
        cnt_d = '0;
        if (one_low) begin
            if (same && (cnt_q != '0))
                cnt_d = (cnt_q == SET4) ? SET4 : cnt_q + 4'd1;
            else
                cnt_d = 4'd1;
        end
        capture = one_low && (cnt_d == SET4) && !(same && (cnt_q == SET4));
    end

    assign frame_done = &seen_q;

`ifdef SEG_CAPTURE_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_fire;
    logic          stall_q;

    // Cycles since the last capture; saturates at TIMEOUT so it fires once.
    always_comb begin
        wd_d    = wd_q;
        wd_fire = 1'b0;
        if (capture) begin
            wd_d = '0;
        end else if (wd_q != WW'(TIMEOUT)) begin
            wd_d    = wd_q + WW'(1);
            wd_fire = (wd_d == WW'(TIMEOUT));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (capture)
                stall_q <= 1'b0;
            else if (wd_fire)
                stall_q <= 1'b1;
        end
    end

    assign bus.stall = stall_q;
`endif

    // Digit store and seen mask. A completed mask is consumed (cleared) in the
    // cycle after it filled; a capture in that same cycle starts the next frame.
    always_comb begin
        seen_d = frame_done ? '0 : seen_q;
        dig_d  = dig_q;
        derr_d = derr_q;
`ifdef SEG_CAPTURE_WATCHDOG_EN
        if (wd_fire) begin
            seen_d = '0;
            dig_d  = '0;
            derr_d = '0;
        end
`endif
        if (capture) begin
            seen_d[idx] = 1'b1;
            dig_d[idx]  = dec[3:0];
            derr_d[idx] = dec[4];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q  <= '0;
            seg_q  <= '0;
            cnt_q  <= '0;
            seen_q <= '0;
            dig_q  <= '0;
            derr_q <= '0;
            val_q  <= '0;
            oerr_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sel_q  <= bus.dig_sel_n;
            seg_q  <= bus.seg_n;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
            dig_q  <= dig_d;
            derr_q <= derr_d;
            if (frame_done) begin
                // Load when the slot is empty or being emptied this cycle;
                // otherwise the held frame wins and the new one is dropped.
                if (!vld_q || bus.out_ready) begin
                    val_q  <= dig_q;
                    oerr_q <= derr_q;
                    vld_q  <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (vld_q && bus.out_ready) begin
                vld_q <= 1'b0;
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.out_value = val_q;
    assign bus.out_err   = oerr_q;
    assign bus.out_valid = vld_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the team's 7-segment encoder.
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus active-low digit selects) and samples each digit once its pattern has settled.
- Decodes each segment pattern back to a 4-bit hex nibble and assembles a full multi-digit value per scan frame.
- Presents each frame on a valid/ready interface for the processor's I/O or a test monitor.

Parameters:
- NDIG, 4, number of multiplexed digits; out_value width is 4*NDIG.
- SETTLE, 3, consecutive identical cycles (same select, same segments) required before a digit is captured; legal range 1..15.
- TIMEOUT, 1024, stall watchdog limit in cycles; used only with SEG_CAPTURE_WATCHDOG_EN.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- seg_n  in  7  segment lines, active-low, bit0=a .. bit6=g.
- dig_sel_n  in  NDIG  digit selects, active-low; bit k low selects digit k.
- out_value  out  4*NDIG  digit k occupies out_value[4k+3:4k].
- out_err  out  NDIG  bit k set = digit k pattern not in decode table.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: a completed frame was dropped.
- stall  out  1  present only with SEG_CAPTURE_WATCHDOG_EN.

Behaviour:
- Reset (async) clears all state. All outputs reset to 0; per-digit registers, seen mask, and dwell counter are also cleared.
- Reset mid-frame discards partial digits.
- Decode table (seg_n[6:0] -> nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
- Any other pattern, including blank 1111111, decodes to nibble 0 with the error bit set.
- Valid sample: dig_sel_n has exactly one bit low. Zero or multiple low bits mean no sample, and the dwell count goes to 0.
- Dwell counter:
  - Count = 1 on the first valid cycle of a new (dig_sel_n, seg_n) pair.
  - Increments while the pair is unchanged and saturates at SETTLE.
  - Any change restarts the count at 1 (if valid) or 0.
- Capture:
  - On the cycle the count reaches SETTLE, the digit nibble, error bit, and seen[k] register at that clock edge.
  - Exactly one capture per dwell; a longer dwell does not recapture.
  - Recapturing a digit already seen in the current frame overwrites it.
- Frame complete: the seen mask is all ones after the capture edge. Evaluated the following cycle, with the seen mask cleared in that same cycle:
  - out_valid=0, or out_valid=1 with out_ready=1: load out_value/out_err and set out_valid=1. This is the simultaneous accept-and-load case; out_valid stays 1 and overrun is unchanged.
  - out_valid=1 with out_ready=0: drop the frame (held data unchanged) and set overrun=1.
- Latency: out_valid rises exactly 1 cycle after the capture edge of the last missing digit.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both high.
  - out_value and out_err are stable while out_valid is high and out_ready is low.
  - After a transfer with no new frame, out_valid=0 next cycle.
  - overrun clears on a transfer.
- Digit order on the bus is arbitrary. Frames are based on set membership, not scan order.

Optional Feature:
- SEG_CAPTURE_WATCHDOG_EN defined:
  - Adds the stall output and a counter of cycles since the last capture.
  - When the counter reaches TIMEOUT: stall=1, and the seen mask plus any partial frame are cleared.
  - stall clears at the next capture. The counter resets on every capture.
- Not defined: no stall port and no watchdog logic; a partial frame waits indefinitely.

Test Plan:
- NDIG=4, SETTLE=3. Drive digits 0,1,2,3 with patterns for 1,2,3,4, 4 cycles each, out_ready=1 -> out_valid pulses 1 cycle after digit 3's capture with out_value=16'h4321, out_err=4'b0000.
- Same scan but digit 1 dwells only 2 cycles -> no frame. Re-drive digit 1 with 0001000 for 3 cycles -> out_value=16'h43A1.
- Digit 2 driven 1111110 -> out_value[11:8]=0, out_err=4'b0100.
- Two full frames (h1234, then h5678) with out_ready=0 -> out_value stays 16'h1234 and overrun=1. Assert out_ready -> out_valid falls next cycle and overrun=0.
- Two select bits low, or a segment change every cycle, for 20 cycles -> no captures and out_valid stays 0.
- Assert Reset after 2 digits captured, then a full scan of h9F0E -> single frame with out_value=16'h9F0E. With SEG_CAPTURE_WATCHDOG_EN and TIMEOUT=16, idle bus for 16 cycles -> stall=1, then cleared by the next capture.
